fetch: RTL and testbench
========================

Name: fetch

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC, issues requests to a synchronous-read instruction memory (1-cycle read latency), and holds the IF/ID pipeline register that drives decode's instruction, PC, next-PC, valid and flush inputs.
- Absorbs decode back-pressure (hold) with a 1-entry skid buffer.
- Redirects on execute-stage taken branches and decode-stage jumps.

Parameters:
- RESET_ADDR, 32'h0000_0000, first PC fetched after reset.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  reset; asynchronous, active-low
- o_imem_ren  out  1  imem read request this cycle
- o_imem_raddr  out  32  imem word address (byte address, [1:0]=0)
- i_imem_rdata  in  32  imem data; valid the cycle after o_imem_ren
- i_hold  in  1  decode stall; IF/ID must not advance
- i_jal  in  1  decode has a jal/jalr; redirect to i_jal_target
- i_jal_target  in  32  jump target from decode
- i_br_taken  in  1  execute resolved a taken branch
- i_br_target  in  32  branch target from execute
- i_halt  in  1  break/trap committed; stop fetching
- o_inst  out  32  IF/ID instruction
- o_pc  out  32  IF/ID PC
- o_nxt_pc  out  32  o_pc + 4
- o_vld  out  1  IF/ID entry valid
- o_flush  out  1  one-cycle pulse: decode must squash its current instruction

Behaviour:
- Async reset (i_rst_n=0):
  - state=S_BOOT; pc_ff=RESET_ADDR; req_vld_ff=0; skid_vld_ff=0.
  - o_inst=32'h00000033; o_pc=RESET_ADDR; o_nxt_pc=RESET_ADDR+4; o_vld=0; o_flush=0.
- o_imem_raddr = pc_ff. o_imem_ren = (state==S_RUN) & ~i_hold & ~redirect & ~skid_vld_ff.
- State machine:
  - S_BOOT: one idle cycle after reset release, then S_RUN.
  - S_RUN: normal operation; i_halt -> S_HALT.
  - S_HALT: no requests issued; o_vld forced 0 next cycle; left only by reset.
- Request tracking:
  - When o_imem_ren=1: req_vld_ff<=1, req_pc_ff<=pc_ff, pc_ff<=pc_ff+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). Otherwise req_vld_ff<=0.
- Latency: PC issued in cycle N, data returned in N+1, IF/ID (o_inst/o_pc/o_vld) updated at the end of N+1, presented to decode in N+2.
- IF/ID update when ~i_hold:
  - If skid_vld_ff: load from skid, clear skid.
  - Else if req_vld_ff: load {i_imem_rdata, req_pc_ff}, o_vld<=1.
  - Else o_vld<=0 and o_inst<=32'h00000033.
- Hold: IF/ID holds all fields. If req_vld_ff returns data in a held cycle, it is captured in the skid buffer. Skid full blocks new requests, so no data is ever lost or duplicated.
- Redirect (redirect = i_br_taken | i_jal, state==S_RUN):
  - i_br_taken has priority over i_jal (older instruction).
  - pc_ff <= {target[31:2],2'b00}; req_vld_ff<=0; skid_vld_ff<=0; o_vld<=0; o_inst<=nop; o_flush<=1 for exactly one cycle.
  - Redirect overrides i_hold.
- Priority: reset > i_halt > redirect > hold > normal.
- Simultaneous redirect and skid/data return: returned data is discarded.
- Reset mid-operation: all state returns to reset values immediately, independent of clock.

Decomposition:
- Shared package constants:
  - NOP_INST = 32'h00000033
  - INST_BYTES = 4
  - fetch state encoding {S_BOOT, S_RUN, S_HALT} (2-bit)
- One natural sub-module: fetch_skid (1-entry 64-bit {inst,pc} skid buffer with load/drain/clear).
- PC and FSM stay in fetch.

Test Plan:
- Reset release with RESET_ADDR=0, imem[i]=i -> o_imem_raddr=0 on cycle 1 after S_BOOT; o_vld=1, o_pc=0, o_inst=0 two cycles later; o_pc increments 0,4,8 with o_nxt_pc=o_pc+4.
- i_hold for 3 cycles mid-stream at o_pc=8 -> o_pc stays 8, skid captures PC 12. After release o_pc=12 then 16, with no gap, duplicate or skip.
- i_jal=1, i_jal_target=32'h100 while i_hold=1 -> o_flush pulses 1 cycle; next valid o_pc=32'h100; the in-flight PC is never presented.
- i_br_taken=1 (target 32'h200) and i_jal=1 (target 32'h300) same cycle -> next valid o_pc=32'h200.
- PC=32'hFFFF_FFF8 sequential -> o_pc FFFF_FFF8, FFFF_FFFC, then 0.
- i_halt=1 -> o_imem_ren=0 forever, o_vld=0 next cycle. Async i_rst_n=0 mid-cycle then release -> restart at RESET_ADDR with o_inst=32'h00000033.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0033;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    // One IF/ID slot: fetched instruction word and the PC it came from
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ifid_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage connections: instruction memory port plus decode/execute side.
interface fetch_if;
    import fetch_pkg::*;

    logic            o_imem_ren;
    logic [XLEN-1:0] o_imem_raddr;
    logic [XLEN-1:0] i_imem_rdata;
    logic            i_hold;
    logic            i_jal;
    logic [XLEN-1:0] i_jal_target;
    logic            i_br_taken;
    logic [XLEN-1:0] i_br_target;
    logic            i_halt;
    logic [XLEN-1:0] o_inst;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_nxt_pc;
    logic            o_vld;
    logic            o_flush;

    modport master (
        output o_imem_ren, o_imem_raddr, o_inst, o_pc, o_nxt_pc, o_vld, o_flush,
        input  i_imem_rdata, i_hold, i_jal, i_jal_target, i_br_taken, i_br_target, i_halt
    );

    modport slave (
        input  o_imem_ren, o_imem_raddr, o_inst, o_pc, o_nxt_pc, o_vld, o_flush,
        output i_imem_rdata, i_hold, i_jal, i_jal_target, i_br_taken, i_br_target, i_halt
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry {inst,pc} buffer catching memory data that returns while decode stalls.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  ifid_entry_t data_i,
    output logic        vld_o,
    output ifid_entry_t data_o
);

    logic        vld_q;
    ifid_entry_t data_q;

    // Clear (redirect/halt) wins over a same-cycle load so stale data is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            if (clear_i)      vld_q <= 1'b0;
            else if (load_i)  vld_q <= 1'b1;
            else if (drain_i) vld_q <= 1'b0;
            if (load_i && !clear_i) data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, synchronous imem requests, IF/ID register with skid and redirect.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input logic     i_clk,
    input logic     i_rst_n,
    fetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_vld_q, req_vld_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    ifid_entry_t     ifid_q, ifid_d;
    logic [XLEN-1:0] nxt_pc_q, nxt_pc_d;
    logic            vld_q, vld_d;
    logic            flush_q, flush_d;

    logic            skid_vld, skid_load, skid_drain, skid_clear;
    ifid_entry_t     skid_data, ret_entry;
    logic            redirect, halting, imem_ren;
    logic [XLEN-1:0] redirect_target;

    assign redirect        = (state_q == S_RUN) && (bus.i_br_taken || bus.i_jal);
    assign halting         = ((state_q == S_RUN) && bus.i_halt) || (state_q == S_HALT);
    assign imem_ren        = (state_q == S_RUN) && !bus.i_hold && !redirect && !skid_vld;
    // Execute-stage branch belongs to the older instruction, so it beats a decode jump
    assign redirect_target = word_align(bus.i_br_taken ? bus.i_br_target : bus.i_jal_target);
    assign ret_entry       = '{inst: bus.i_imem_rdata, pc: req_pc_q};

    fetch_skid u_skid (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .data_i  (ret_entry),
        .vld_o   (skid_vld),
        .data_o  (skid_data)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_vld_d  = 1'b0;
        req_pc_d   = req_pc_q;
        ifid_d     = ifid_q;
        nxt_pc_d   = nxt_pc_q;
        vld_d      = vld_q;
        flush_d    = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (bus.i_halt) state_d = S_HALT;
            default: state_d = state_q;
        endcase

        if (imem_ren) begin
            req_vld_d = 1'b1;
            req_pc_d  = pc_q;
            pc_d      = pc_q + XLEN'(INST_BYTES);
        end

        // Priority: halt > redirect > hold > normal advance
        if (halting) begin
            req_vld_d   = 1'b0;
            skid_clear  = 1'b1;
            vld_d       = 1'b0;
            ifid_d.inst = NOP_INST;
        end else if (redirect) begin
            pc_d        = redirect_target;
            req_vld_d   = 1'b0;
            skid_clear  = 1'b1;
            vld_d       = 1'b0;
            ifid_d.inst = NOP_INST;
            flush_d     = 1'b1;
        end else if (!bus.i_hold) begin
            if (skid_vld) begin
                ifid_d     = skid_data;
                nxt_pc_d   = skid_data.pc + XLEN'(INST_BYTES);
                vld_d      = 1'b1;
                skid_drain = 1'b1;
            end else if (req_vld_q) begin
                ifid_d   = ret_entry;
                nxt_pc_d = req_pc_q + XLEN'(INST_BYTES);
                vld_d    = 1'b1;
            end else begin
                vld_d       = 1'b0;
                ifid_d.inst = NOP_INST;
            end
        end else if (req_vld_q) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_ADDR;
            req_vld_q <= 1'b0;
            req_pc_q  <= RESET_ADDR;
            ifid_q    <= '{inst: NOP_INST, pc: RESET_ADDR};
            nxt_pc_q  <= RESET_ADDR + XLEN'(INST_BYTES);
            vld_q     <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_vld_q <= req_vld_d;
            req_pc_q  <= req_pc_d;
            ifid_q    <= ifid_d;
            nxt_pc_q  <= nxt_pc_d;
            vld_q     <= vld_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.o_imem_ren   = imem_ren;
    assign bus.o_imem_raddr = pc_q;
    assign bus.o_inst       = ifid_q.inst;
    assign bus.o_pc         = ifid_q.pc;
    assign bus.o_nxt_pc     = nxt_pc_q;
    assign bus.o_vld        = vld_q;
    assign bus.o_flush      = flush_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: imem model returns word index, scoreboard of expected PCs popped on each decode accept.
module tb_fetch;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fetch_if bus ();

    fetch #(.RESET_ADDR(32'h0000_0000)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory: imem[i] = i
    always @(posedge clk) begin
        if (bus.o_imem_ren === 1'b1) bus.i_imem_rdata <= bus.o_imem_raddr >> 2;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    // Called just after a negedge with this cycle's inputs set; scores a decode accept
    task automatic tick();
        logic [31:0] e;
        #1;
        if (rst_n && bus.o_vld && !bus.i_hold && !bus.i_jal && !bus.i_br_taken && !bus.i_halt) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_vld", 32'(bus.o_vld), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pc", bus.o_pc, e);
                check_eq("inst", bus.o_inst, e >> 2);
                check_eq("nxt_pc", bus.o_nxt_pc, e + 32'd4);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            tick();
            budget++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_vld"}, 32'(bus.o_vld), 32'd0);
        check_eq({tag, "_inst"}, bus.o_inst, 32'h0000_0033);
        check_eq({tag, "_pc"}, bus.o_pc, 32'h0000_0000);
        check_eq({tag, "_nxt_pc"}, bus.o_nxt_pc, 32'h0000_0004);
        check_eq({tag, "_flush"}, 32'(bus.o_flush), 32'd0);
        check_eq({tag, "_ren"}, 32'(bus.o_imem_ren), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        bus.i_hold       = 1'b0;
        bus.i_jal        = 1'b0;
        bus.i_jal_target = 32'h0;
        bus.i_br_taken   = 1'b0;
        bus.i_br_target  = 32'h0;
        bus.i_halt       = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check_reset_outputs("reset");

        // Boot: one idle cycle, then the first request goes to RESET_ADDR
        @(negedge clk);
        rst_n = 1'b1;
        push_stream(32'h0, 8);
        #1 check_eq("boot_ren", 32'(bus.o_imem_ren), 32'd0);
        @(negedge clk);
        #1 check_eq("run_ren", 32'(bus.o_imem_ren), 32'd1);
        check_eq("run_raddr", bus.o_imem_raddr, 32'h0);

        // Run until PC 8 is presented, then stall decode for three cycles
        waited = 0;
        while (!(bus.o_vld && bus.o_pc == 32'h8) && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("reach_pc8", bus.o_pc, 32'h8);
        bus.i_hold = 1'b1;
        repeat (3) tick();
        check_eq("hold_pc", bus.o_pc, 32'h8);
        check_eq("hold_vld", 32'(bus.o_vld), 32'd1);
        bus.i_hold = 1'b0;
        drain("drain_stream");

        // Jump from decode while stalled
        bus.i_hold       = 1'b1;
        bus.i_jal        = 1'b1;
        bus.i_jal_target = 32'h0000_0100;
        push_stream(32'h100, 4);
        tick();
        bus.i_hold = 1'b0;
        bus.i_jal  = 1'b0;
        #1 check_eq("jal_flush", 32'(bus.o_flush), 32'd1);
        check_eq("jal_vld", 32'(bus.o_vld), 32'd0);
        tick();
        check_eq("jal_flush_end", 32'(bus.o_flush), 32'd0);
        drain("drain_jal");

        // Branch and jump together: branch wins
        bus.i_br_taken   = 1'b1;
        bus.i_br_target  = 32'h0000_0200;
        bus.i_jal        = 1'b1;
        bus.i_jal_target = 32'h0000_0300;
        push_stream(32'h200, 4);
        tick();
        bus.i_br_taken = 1'b0;
        bus.i_jal      = 1'b0;
        #1 check_eq("br_flush", 32'(bus.o_flush), 32'd1);
        drain("drain_br");

        // PC wrap across the top of the address space
        bus.i_jal        = 1'b1;
        bus.i_jal_target = 32'hFFFF_FFF8;
        push_stream(32'hFFFF_FFF8, 4);
        tick();
        bus.i_jal = 1'b0;
        drain("drain_wrap");

        // Asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        push_stream(32'h0, 4);
        drain("drain_restart");

        // Halt: no more requests, IF/ID goes invalid
        bus.i_halt = 1'b1;
        tick();
        bus.i_halt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("halt_ren", 32'(bus.o_imem_ren), 32'd0);
            check_eq("halt_vld", 32'(bus.o_vld), 32'd0);
            @(negedge clk);
        end

        // Only reset leaves halt
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("halt_rst");
        @(negedge clk);
        rst_n = 1'b1;
        push_stream(32'h0, 2);
        drain("drain_after_halt");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
